// File: rtl/pong_game_core.sv
// pong_game_core: per-frame Pong game state and registered 1-bit RGB pixel generator
module pong_game_core #(
   parameter int PADDLE_W     = 64,
   parameter int PADDLE_SPEED = 4,
   parameter int BALL_SPEED   = 2,
   parameter int SERVE_FRAMES = 60,
   parameter int MISS_FRAMES  = 30
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] CounterX,
   input  logic [8:0] CounterY,
   input  logic       inDisplayArea,
   input  logic       btn_left,
   input  logic       btn_right,
   output logic       vga_r,
   output logic       vga_g,
   output logic       vga_b,
   output logic [7:0] score,
   output logic [3:0] miss_count,
   output logic [1:0] game_state
);
   typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;
   localparam logic [10:0] PMIN = 11'd8;
   localparam logic [10:0] PMAX = 11'(632 - PADDLE_W);
   localparam logic [10:0] PS   = 11'(PADDLE_SPEED);
   localparam logic [10:0] BS   = 11'(BALL_SPEED);
   localparam logic [10:0] W    = 11'(PADDLE_W);
   state_t      state_q, state_d;
   logic [1:0]  bl_q, br_q;
   logic        edge_q, at_tick, tick;
   logic [9:0]  px_q, px_d, bx_q, bx_d;
   logic [8:0]  by_q, by_d;
   logic        dx_q, dx_d, dy_q, dy_d, tog_q, tog_d;
   logic [7:0]  score_q, score_d;
   logic [3:0]  miss_q, miss_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  rgb_q, rgb_d;
   logic [10:0] pxw, bx11, by11, cx11, cy11, px_l, px_r;
   logic        ball_on, pad_on, wall_on;
   assign pxw     = {1'b0, px_q};
   assign bx11    = {1'b0, bx_q};
   assign by11    = {2'b0, by_q};
   assign cx11    = {1'b0, CounterX};
   assign cy11    = {2'b0, CounterY};
   assign at_tick = (CounterY == 9'd480) && (CounterX == 10'd0);
   assign tick    = at_tick && !edge_q;
   assign px_l    = (pxw < PMIN + PS) ? PMIN : pxw - PS;
   assign px_r    = (pxw + PS > PMAX) ? PMAX : pxw + PS;
   // paddle moves only when exactly one synchronized button is held, clamped inside the walls
   always_comb begin
      px_d = !tick ? px_q : (bl_q[1] && !br_q[1]) ? px_l[9:0] : (br_q[1] && !bl_q[1]) ? px_r[9:0] : px_q;
   end
   // serve / play / miss sequencing and ball motion, evaluated once per frame
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bx_d    = bx_q;
      by_d    = by_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      tog_d   = tog_q;
      score_d = score_q;
      miss_d  = miss_q;
      if (tick) begin
         case (state_q)
            SERVE: begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'(SERVE_FRAMES - 1)) begin
                  state_d = PLAY;
                  cnt_d   = '0;
                  dx_d    = tog_q;
                  dy_d    = 1'b0;
                  tog_d   = !tog_q;
               end
            end
            PLAY: begin
               if (bx11 <= 11'd8) dx_d = 1'b0;
               if (bx11 >= 11'd624) dx_d = 1'b1;
               if (by11 <= 11'd8) dy_d = 1'b0;
               if (!dy_d && by11 >= 11'd456 && by11 <= 11'd463 && bx11 + 11'd8 > pxw && bx11 < pxw + W) begin
                  dy_d    = 1'b1;
                  score_d = score_q + 8'd1;
               end else if (by11 >= 11'd472) begin
                  state_d = MISS;
                  cnt_d   = '0;
                  miss_d  = (miss_q == 4'd15) ? miss_q : miss_q + 4'd1;
               end
               bx_d = 10'(dx_d ? bx11 - BS : bx11 + BS);
               by_d = 9'(dy_d ? by11 - BS : by11 + BS);
            end
            MISS: begin
               cnt_d = cnt_q + 16'd1;
               if (cnt_q == 16'(MISS_FRAMES - 1)) begin
                  state_d = SERVE;
                  cnt_d   = '0;
                  bx_d    = 10'd316;
                  by_d    = 9'd236;
               end
            end
            default: state_d = SERVE;
         endcase
      end
   end
   // pixel colour by priority: blanking, ball, paddle, walls
   always_comb begin
      ball_on = (state_q != MISS) && cx11 >= bx11 && cx11 < bx11 + 11'd8 && cy11 >= by11 && cy11 < by11 + 11'd8;
      pad_on  = cy11 >= 11'd464 && cy11 <= 11'd471 && cx11 >= pxw && cx11 < pxw + W;
      wall_on = cy11 < 11'd8 || cx11 < 11'd8 || cx11 >= 11'd632;
      rgb_d   = !inDisplayArea ? 3'b000 : ball_on ? 3'b111 : pad_on ? 3'b010 : wall_on ? ((state_q == MISS) ? 3'b100 : 3'b001) : 3'b000;
   end
   // button synchronizers, frame edge detector and registered colour
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bl_q   <= '0;
         br_q   <= '0;
         edge_q <= 1'b0;
         rgb_q  <= '0;
      end else begin
         bl_q   <= {bl_q[0], btn_left};
         br_q   <= {br_q[0], btn_right};
         edge_q <= at_tick;
         rgb_q  <= rgb_d;
      end
   end
   // game state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SERVE;
         cnt_q   <= '0;
         px_q    <= 10'd288;
         bx_q    <= 10'd316;
         by_q    <= 9'd236;
         dx_q    <= 1'b0;
         dy_q    <= 1'b0;
         tog_q   <= 1'b0;
         score_q <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         px_q    <= px_d;
         bx_q    <= bx_d;
         by_q    <= by_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         tog_q   <= tog_d;
         score_q <= score_d;
         miss_q  <= miss_d;
      end
   end
   assign {vga_r, vga_g, vga_b} = rgb_q;
   assign score      = score_q;
   assign miss_count = miss_q;
   assign game_state = state_q;
endmodule
